// File: rtl/bcd_pkg.sv
// Shared types, limits and 7-segment decode for the multi-digit BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] seg_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Active-low patterns, bit7 = decimal point (held off)
    localparam seg_t SEG_LUT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    localparam seg_t SEG_BLANK = 8'hFF;

    function automatic seg_t bcd_to_seg(input bcd_digit_t d);
        seg_t s;
        s = SEG_BLANK;
        if (d <= BCD_MAX)
            s = SEG_LUT[d];
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register; wrap flags the digit sitting at its terminal value
// for the current direction, so the top can chain it into the next digit's step.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t ld_val,
    input  logic       step,
    input  logic       up_dn,
    output bcd_digit_t value,
    output logic       wrap
);

    always_comb begin
        wrap = up_dn ? (value == BCD_MAX) : (value == 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= ld_val;
        end else if (step) begin
            if (up_dn)
                value <= wrap ? 4'd0 : value + 4'd1;
            else
                value <= wrap ? BCD_MAX : value - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with parallel load, terminal count and
// per-digit 7-segment decode. Define BCD_SATURATE_EN to saturate instead of wrap.
module bcd_counter_multi
    import bcd_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  load_err,
    output logic [8*DIGITS-1:0]   disp
);

    localparam seg_t SEG_INV = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;

    logic [DIGITS-1:0][3:0] dval;
    logic [DIGITS-1:0][3:0] ldv;
    logic [DIGITS-1:0][3:0] qd;
    logic [DIGITS-1:0]      bad;
    logic [DIGITS-1:0]      wrap;
    logic [DIGITS-1:0]      step;
    logic                   all_term;
    logic                   cnt_ok;

    assign dval     = data;
    assign q        = qd;
    assign all_term = &wrap;
    assign cnt_ok   = en & ~load;
    assign tc       = cnt_ok & all_term;

`ifdef BCD_SATURATE_EN
    // Suppressing the first step freezes the whole ripple chain at the limit
    assign step[0] = cnt_ok & ~all_term;
`else
    assign step[0] = cnt_ok;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign bad[i] = (dval[i] > BCD_MAX);
        assign ldv[i] = bad[i] ? 4'd0 : dval[i];

        if (i < DIGITS - 1) begin : g_carry
            assign step[i+1] = step[i] & wrap[i];
        end

        bcd_digit u_dig (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .ld_val (ldv[i]),
            .step   (step[i]),
            .up_dn  (up_dn),
            .value  (qd[i]),
            .wrap   (wrap[i])
        );

        assign disp[8*i +: 8] = bcd_to_seg(qd[i]) ^ SEG_INV;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            load_err <= 1'b0;
        else
            load_err <= load & (|bad);
    end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Randomized bench for bcd_counter_multi against an integer reference model.
module tb_bcd_counter_multi;

    localparam int D   = 4;
    localparam int MOD = 10000;
`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [4*D-1:0] data = '0;
    logic [4*D-1:0] q;
    logic          tc, load_err;
    logic [8*D-1:0] disp;

    int n_chk = 0;
    int n_err = 0;
    int cnt   = 0;
    bit lerr  = 1'b0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(D), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .data(data), .q(q), .tc(tc), .load_err(load_err), .disp(disp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [8*D-1:0] to_disp(input int v);
        logic [8*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[8*i +: 8] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int load_val(input logic [4*D-1:0] d);
        int v, p, nib;
        v = 0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            nib = int'(d[4*i +: 4]);
            if (nib <= 9) v += nib * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [4*D-1:0] d);
        bit b;
        b = 1'b0;
        for (int i = 0; i < D; i++)
            if (d[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_q"}, 32'(q), 32'(to_bcd(cnt)));
        check({tag, "_disp"}, 32'(disp), 32'(to_disp(cnt)));
        check({tag, "_lerr"}, 32'(load_err), 32'(lerr));
    endtask

    // One clock: drive inputs, check tc before the edge, check state after.
    task automatic cyc(input bit e, input bit u, input bit l,
                       input logic [4*D-1:0] d, input string tag);
        int nxt;
        bit nerr;
        en = e; up_dn = u; load = l; data = d;
        #1;
        check({tag, "_tc"}, 32'(tc), 32'(e && !l && (u ? cnt == MOD-1 : cnt == 0)));
        nxt  = cnt;
        nerr = 1'b0;
        if (l) begin
            nxt  = load_val(d);
            nerr = has_bad(d);
        end else if (e) begin
            if (u)
                nxt = (cnt == MOD-1) ? (SAT ? cnt : 0) : cnt + 1;
            else
                nxt = (cnt == 0) ? (SAT ? cnt : MOD-1) : cnt - 1;
        end
        @(posedge clk);
        #1;
        cnt  = nxt;
        lerr = nerr;
        check_state(tag);
    endtask

    initial begin
        logic [4*D-1:0] rd;
        #3;
        check_state("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Count up then assert reset between edges
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, '0, "up5");
        #2;
        rst = 1'b0;
        #1;
        cnt = 0; lerr = 1'b0;
        check("async_q", 32'(q), 32'h0);
        check("async_disp", 32'(disp), 32'hC0C0C0C0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        cyc(0, 1, 1, 16'h0099, "ld99");
        cyc(1, 1, 0, '0,       "carry");
        cyc(0, 1, 1, 16'h9999, "ld9999");
        cyc(1, 1, 0, '0,       "wrapup");
        cyc(0, 1, 1, 16'h0000, "ld0");
        cyc(1, 0, 0, '0,       "wrapdn");
        cyc(1, 0, 0, '0,       "dn9998");
        cyc(0, 1, 1, 16'h3A7F, "ldbad");
        cyc(0, 1, 0, '0,       "errclr");
        cyc(0, 1, 1, 16'h0005, "ld5");
        cyc(1, 1, 1, 16'h0042, "ldwins");
        cyc(0, 0, 0, '0,       "hold");

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rd = 16'h9999;
                1:       rd = 16'h0000;
                default: rd = 16'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0, rd, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
